// File: rtl/wave_gen.sv
// Multi-mode waveform generator (triangle, rising/falling saw, square) within a [lo, hi] window.
// All outputs registered; a sample updates on the tick edge. Free-running source with no backpressure.
module wave_gen #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] step,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] wave,
  output logic             dir,
  output logic             period
);

  typedef struct packed {
    logic [1:0]       mode;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] step;
    logic [DIV_W-1:0] div;
  } cfg_t;

  localparam cfg_t CFG_RST = {2'b00, {WIDTH{1'b0}}, {WIDTH{1'b1}}, WIDTH'(1), {DIV_W{1'b0}}};

  cfg_t             cfg;
  logic [DIV_W-1:0] pc;
  logic [WIDTH-1:0] sq;
  logic             tick;

  logic [WIDTH-1:0] s_w, dn_w;
  logic [WIDTH:0]   s_x, lo_x, hi_x, w_x, up_x, lo_step_x;
  logic [WIDTH-1:0] wave_nxt, sq_nxt;
  logic             dir_nxt, period_nxt;

  assign tick = (pc == cfg.div);

  always_comb begin
    // A zero ramp step would stall the ramp, so it runs as 1; square uses step as a tick count.
    s_w = cfg.step;
    if (cfg.mode != 2'd3 && cfg.step == '0)
      s_w = WIDTH'(1);
    s_x       = {1'b0, s_w};
    lo_x      = {1'b0, cfg.lo};
    hi_x      = {1'b0, cfg.hi};
    w_x       = {1'b0, wave};
    up_x      = w_x + s_x;
    lo_step_x = lo_x + s_x;
    dn_w      = wave - s_w;

    wave_nxt   = wave;
    dir_nxt    = (cfg.mode == 2'd0) ? dir : 1'b0;
    period_nxt = 1'b0;
    sq_nxt     = sq;

    if (cfg.lo >= cfg.hi) begin
      wave_nxt = cfg.lo;
      dir_nxt  = 1'b0;
    end else if (tick) begin
      case (cfg.mode)
        2'd0: begin
          if (!dir) begin
            if (up_x >= hi_x) begin
              wave_nxt = cfg.hi;
              dir_nxt  = 1'b1;
            end else begin
              wave_nxt = up_x[WIDTH-1:0];
            end
          end else if (w_x <= lo_step_x) begin
            wave_nxt   = cfg.lo;
            dir_nxt    = 1'b0;
            period_nxt = 1'b1;
          end else begin
            wave_nxt = dn_w;
          end
        end
        2'd1: begin
          if (up_x > hi_x) begin
            wave_nxt   = cfg.lo;
            period_nxt = 1'b1;
          end else begin
            wave_nxt = up_x[WIDTH-1:0];
          end
        end
        2'd2: begin
          if (w_x < lo_step_x) begin
            wave_nxt   = cfg.hi;
            period_nxt = 1'b1;
          end else begin
            wave_nxt = dn_w;
          end
        end
        default: begin
          if (sq == cfg.step) begin
            sq_nxt = '0;
            if (wave == cfg.lo) begin
              wave_nxt   = cfg.hi;
              period_nxt = 1'b1;
            end else begin
              wave_nxt = cfg.lo;
            end
          end else begin
            sq_nxt = sq + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg    <= CFG_RST;
      pc     <= '0;
      sq     <= '0;
      wave   <= '0;
      dir    <= 1'b0;
      period <= 1'b0;
    end else if (!en) begin
      cfg    <= {mode, lo, hi, step, div};
      pc     <= '0;
      sq     <= '0;
      wave   <= lo;
      dir    <= 1'b0;
      period <= 1'b0;
    end else begin
      pc     <= tick ? '0 : pc + 1'b1;
      sq     <= sq_nxt;
      wave   <= wave_nxt;
      dir    <= dir_nxt;
      period <= period_nxt;
    end
  end

endmodule

// File: tb/tb_wave_gen.sv
// Bench for wave_gen: closed-form expected samples queued per edge, popped and compared at negedge.
module tb_wave_gen;
  localparam int W  = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    mode = '0;
  logic [W-1:0]  lo = '0, hi = '0, step = '0;
  logic [DW-1:0] div = '0;
  logic [W-1:0]  wave;
  logic          dir, period;

  always #5 clk = ~clk;

  wave_gen #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .lo(lo), .hi(hi),
    .step(step), .div(div), .wave(wave), .dir(dir), .period(period)
  );

  typedef struct {
    int mode; int lo; int hi; int step; int div; int edges; int per_ticks;
  } case_t;
  typedef struct { int wave; int dir; int period; } exp_t;

  exp_t sb[$];
  int passes = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Expected outputs after k ticks, from the closed-form shape of each waveform.
  function automatic exp_t model(input case_t c, input int k, input bit ticked);
    exp_t r;
    int s, d, n, p, t;
    r.wave = c.lo; r.dir = 0; r.period = 0;
    s = (c.mode != 3 && c.step == 0) ? 1 : c.step;
    if (c.lo >= c.hi || k == 0) return r;
    d = c.hi - c.lo;
    case (c.mode)
      0: begin
        n = (d + s - 1) / s;
        p = k % (2 * n);
        if (p == 0) r.period = int'(ticked);
        else if (p < n) r.wave = c.lo + p * s;
        else if (p == n) begin r.wave = c.hi; r.dir = 1; end
        else begin r.wave = c.hi - (p - n) * s; r.dir = 1; end
      end
      1: begin
        n = d / s + 1; p = k % n;
        r.wave = c.lo + p * s;
        r.period = int'(ticked && p == 0);
      end
      2: begin
        n = d / s + 1; p = (k - 1) % n;
        r.wave = c.hi - p * s;
        r.period = int'(ticked && p == 0);
      end
      default: begin
        t = c.step + 1;
        if ((k / t) % 2 == 1) r.wave = c.hi;
        r.period = int'(ticked && (k % t == 0) && ((k / t) % 2 == 1));
      end
    endcase
    return r;
  endfunction

  task automatic run_case(input case_t c, input bit load, input string tag);
    exp_t e;
    int last, nper, k;
    bit ticked;
    if (load) begin
      en = 1'b0; mode = 2'(c.mode); lo = W'(c.lo); hi = W'(c.hi);
      step = W'(c.step); div = DW'(c.div);
      @(posedge clk); #1;
      check({tag, " idle wave"}, int'(wave), c.lo);
    end
    // Config inputs are scrambled while running; the shadow must ignore them.
    en = 1'b1;
    mode = 2'($urandom); hi = W'($urandom); step = W'($urandom);
    div = DW'($urandom_range(0, 5)); lo = W'($urandom);
    last = -1; nper = 0;
    for (int ed = 0; ed < c.edges; ed++) begin
      ticked = (ed % (c.div + 1)) == c.div;
      k = (ed + 1) / (c.div + 1);
      sb.push_back(model(c, k, ticked));
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("%s e%0d wave", tag, ed), int'(wave), e.wave);
      check($sformatf("%s e%0d dir", tag, ed), int'(dir), e.dir);
      check($sformatf("%s e%0d period", tag, ed), int'(period), e.period);
      if (period) begin
        if (last >= 0)
          check($sformatf("%s spacing e%0d", tag, ed), ed - last, c.per_ticks * (c.div + 1));
        last = ed;
        nper++;
      end
    end
    if (c.per_ticks == 0) check({tag, " strobe count"}, nper, 0);
    else check({tag, " strobe seen"}, int'(nper > 0), 1);
    en = 1'b0; lo = W'(c.lo + 3);
    @(posedge clk); #1;
    check({tag, " drop wave"}, int'(wave), (c.lo + 3) % 256);
    check({tag, " drop period"}, int'(period), 0);
    check({tag, " drop dir"}, int'(dir), 0);
  endtask

  initial begin
    case_t tbl[12];
    case_t dflt;
    //        mode  lo   hi  step div edges per_ticks
    dflt    = '{0,   0, 255,   1,  0, 1100, 510};
    tbl[0]  = '{1,  10,  50,   7,  2,   60,   6};
    tbl[1]  = '{2,   0, 255,   0,  0,  600, 256};
    tbl[2]  = '{3,  20, 200,   3,  0,   40,   8};
    tbl[3]  = '{0, 100, 100,   5,  0,   30,   0};
    tbl[4]  = '{1, 150, 100,   1,  0,   20,   0};
    tbl[5]  = '{0,   0, 250, 100,  0,   20,   6};
    tbl[6]  = '{1,   0,  21,   7,  0,   16,   4};
    tbl[7]  = '{1, 200, 255,  30,  1,   20,   2};
    tbl[8]  = '{2,   0, 255, 200,  0,   12,   2};
    tbl[9]  = '{3,   5,   9,   0,  1,   20,   2};
    tbl[10] = '{0,   5,  20,   4,  1,   40,   8};
    tbl[11] = '{2,  40,  60,   3,  3,   60,   7};

    rst = 1'b1; en = 1'b1;
    #12;
    check("reset wave", int'(wave), 0);
    check("reset dir", int'(dir), 0);
    check("reset period", int'(period), 0);
    rst = 1'b0;
    run_case(dflt, 1'b0, "dflt");

    for (int i = 0; i < 12; i++)
      run_case(tbl[i], 1'b1, $sformatf("c%0d", i));

    en = 1'b0; mode = 2'd0; lo = 8'd20; hi = 8'd240; step = 8'd3; div = '0;
    @(posedge clk); #1;
    en = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("pre-rst wave", int'(wave), 50);
    rst = 1'b1;
    #1;
    check("async rst wave", int'(wave), 0);
    check("async rst dir", int'(dir), 0);
    check("async rst period", int'(period), 0);
    en = 1'b0; lo = 8'd10;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("post-rst load wave", int'(wave), 10);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
